// File: rtl/priority_line_decoder_pkg.sv
// Shared definitions for the priority line decoder: index width, FSM states
// and the index-to-one-hot helper.
package priority_pkg;

  localparam int IDX_W = 2;
  localparam int LINES = 1 << IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic logic [LINES-1:0] onehot(input logic [IDX_W-1:0] idx);
    return LINES'(1) << idx;
  endfunction

endpackage

// File: rtl/priority_line_decoder_if.sv
// Code handshake and decoded-line bundle for priority_line_decoder.
// Per-line counters exist only when DEC_COUNTERS_EN is defined.
interface priority_line_decoder_if #(
  parameter int CNT_W = 8
);
  logic A1, A0, valid, ready;
  logic D3, D2, D1, D0, busy;
`ifdef DEC_COUNTERS_EN
  logic [CNT_W-1:0] cnt3, cnt2, cnt1, cnt0;

  modport master (output A1, A0, valid,
                  input  ready, D3, D2, D1, D0, busy, cnt3, cnt2, cnt1, cnt0);
  modport slave  (input  A1, A0, valid,
                  output ready, D3, D2, D1, D0, busy, cnt3, cnt2, cnt1, cnt0);
`else
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  modport master (output A1, A0, valid,
                  input  ready, D3, D2, D1, D0, busy);
  modport slave  (input  A1, A0, valid,
                  output ready, D3, D2, D1, D0, busy);
`endif
endinterface

// File: rtl/priority_line_decoder_hold_counter.sv
// Loadable 8-bit down-counter timing both the pulse and the gap phases.
// Stops at zero; zero_o flags the final cycle of a phase.
module hold_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] value_i,
  output logic       zero_o
);
  logic [7:0] cnt_q;

  // Load takes priority over the decrement; the count parks at zero.
  always_ff @(posedge clk) begin
    if (rst)                cnt_q <= '0;
    else if (load_i)        cnt_q <= value_i;
    else if (cnt_q != '0)   cnt_q <= cnt_q - 8'd1;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/priority_line_decoder.sv
// Registered 2-to-4 line decoder with valid/ready intake, programmable pulse
// length and trailing all-low gap. Optional per-line accepted-code counters
// are built when DEC_COUNTERS_EN is defined.
module priority_line_decoder
  import priority_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  priority_line_decoder_if.slave  bus
);
  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255 || GAP_CYCLES < 0 || GAP_CYCLES > 255 || CNT_W < 1)
  begin : g_bad_param
    $error("priority_line_decoder: parameter out of range");
  end

  state_t             state_q, state_d;
  logic [LINES-1:0]   d_q, d_d;
  logic [IDX_W-1:0]   idx;
  logic               accept;
  logic               ld;
  logic [7:0]         ld_val;
  logic               cnt_zero;

  assign idx    = {bus.A1, bus.A0};
  assign accept = bus.valid && (state_q == ST_IDLE);

  hold_counter u_hold (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ld),
    .value_i (ld_val),
    .zero_o  (cnt_zero)
  );

  // Next state, next decoded lines and phase-counter loads.
  // D is set on the acceptance edge so the line is registered from the first DRIVE cycle.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    ld      = 1'b0;
    ld_val  = HOLD_LD;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          d_d     = onehot(idx);
          ld      = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt_zero) begin
          d_d = '0;
          if (GAP_CYCLES > 0) begin
            ld      = 1'b1;
            ld_val  = GAP_LD;
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (cnt_zero) state_d = ST_IDLE;
      end
      default: begin
        d_d     = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and decoded-line registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
    end
  end

  assign bus.ready = (state_q == ST_IDLE);
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.D0    = d_q[0];
  assign bus.D1    = d_q[1];
  assign bus.D2    = d_q[2];
  assign bus.D3    = d_q[3];

`ifdef DEC_COUNTERS_EN
  logic [CNT_W-1:0] cnt_q [LINES];

  // Saturating count of accepted codes per line.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LINES; i++) cnt_q[i] <= '0;
    end else if (accept && (cnt_q[idx] != '1)) begin
      cnt_q[idx] <= cnt_q[idx] + CNT_W'(1);
    end
  end

  assign bus.cnt0 = cnt_q[0];
  assign bus.cnt1 = cnt_q[1];
  assign bus.cnt2 = cnt_q[2];
  assign bus.cnt3 = cnt_q[3];
`endif
endmodule

// File: tb/tb_priority_line_decoder.sv
// Self-checking bench for priority_line_decoder: DUT A uses HOLD=4/GAP=1,
// DUT B uses HOLD=1/GAP=0; both share stimulus and CNT_W=2.
module tb_priority_line_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_s = 1'b0;
  logic [1:0] a_s = 2'b00;

  int passed = 0;
  int total  = 0;

  priority_line_decoder_if #(.CNT_W(2)) ia ();
  priority_line_decoder_if #(.CNT_W(2)) ib ();

  assign ia.A1 = a_s[1];
  assign ia.A0 = a_s[0];
  assign ia.valid = valid_s;
  assign ib.A1 = a_s[1];
  assign ib.A0 = a_s[0];
  assign ib.valid = valid_s;

  priority_line_decoder #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(2)) dut_a (
    .clk (clk), .rst (rst), .bus (ia.slave));
  priority_line_decoder #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(2)) dut_b (
    .clk (clk), .rst (rst), .bus (ib.slave));

  always #5 clk = ~clk;

  // Timeline reference model: each accepted code is remembered by its edge
  // number; outputs follow from the documented timing formulas.
  int  H [2] = '{4, 1};
  int  G [2] = '{1, 0};
  int  edges = 0;
  int  acc   [2];
  bit  acc_v [2] = '{0, 0};
  int  aidx  [2];
  int  mcnt  [2][4];

  function automatic bit m_ready(int j);
    return !acc_v[j] || (edges + 1 >= acc[j] + H[j] + G[j] + 1);
  endfunction

  function automatic logic [3:0] m_d(int j);
    int cur = edges + 1;
    if (acc_v[j] && cur >= acc[j] + 1 && cur <= acc[j] + H[j]) return 4'(1 << aidx[j]);
    return 4'b0000;
  endfunction

  function automatic logic [3:0] dut_d(int j);
    return (j == 0) ? {ia.D3, ia.D2, ia.D1, ia.D0} : {ib.D3, ib.D2, ib.D1, ib.D0};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_edge(input bit r, input bit v, input int idx);
    bit rd [2];
    for (int j = 0; j < 2; j++) rd[j] = m_ready(j);
    edges++;
    for (int j = 0; j < 2; j++) begin
      if (r) begin
        acc_v[j] = 0;
        for (int i = 0; i < 4; i++) mcnt[j][i] = 0;
      end else if (v && rd[j]) begin
        acc[j] = edges; acc_v[j] = 1; aidx[j] = idx;
        if (mcnt[j][idx] < 3) mcnt[j][idx]++;
      end
    end
  endtask

  task automatic check_model();
    chk("A.D",     int'(dut_d(0)), int'(m_d(0)));
    chk("A.ready", int'(ia.ready), int'(m_ready(0)));
    chk("A.busy",  int'(ia.busy),  int'(!m_ready(0)));
    chk("B.D",     int'(dut_d(1)), int'(m_d(1)));
    chk("B.ready", int'(ib.ready), int'(m_ready(1)));
    chk("B.busy",  int'(ib.busy),  int'(!m_ready(1)));
`ifdef DEC_COUNTERS_EN
    chk("A.cnt0", int'(ia.cnt0), mcnt[0][0]);
    chk("A.cnt1", int'(ia.cnt1), mcnt[0][1]);
    chk("A.cnt2", int'(ia.cnt2), mcnt[0][2]);
    chk("A.cnt3", int'(ia.cnt3), mcnt[0][3]);
    chk("B.cnt0", int'(ib.cnt0), mcnt[1][0]);
    chk("B.cnt1", int'(ib.cnt1), mcnt[1][1]);
    chk("B.cnt2", int'(ib.cnt2), mcnt[1][2]);
    chk("B.cnt3", int'(ib.cnt3), mcnt[1][3]);
`endif
  endtask

  // One clock: drive inputs, model the edge, check on the falling edge.
  task automatic step(input bit r, input bit v, input int idx);
    rst = r; valid_s = v; a_s = 2'(idx);
    @(posedge clk);
    model_edge(r, v, idx);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    bit         r;
    bit         v;
    int         idx;
    logic [3:0] d;
    bit         rdy;
  } vec_t;

  vec_t tbl [11];

  initial begin
    // Single code 2 on DUT A, index changes while busy, reset in 2nd DRIVE cycle,
    // reset beating valid.
    tbl[0]  = '{0, 1, 2, 4'b0100, 0};
    tbl[1]  = '{0, 1, 3, 4'b0100, 0};
    tbl[2]  = '{0, 1, 3, 4'b0100, 0};
    tbl[3]  = '{0, 0, 0, 4'b0100, 0};
    tbl[4]  = '{0, 0, 0, 4'b0000, 0};
    tbl[5]  = '{0, 0, 0, 4'b0000, 1};
    tbl[6]  = '{0, 1, 1, 4'b0010, 0};
    tbl[7]  = '{0, 1, 3, 4'b0010, 0};
    tbl[8]  = '{1, 0, 0, 4'b0000, 1};
    tbl[9]  = '{1, 1, 3, 4'b0000, 1};
    tbl[10] = '{0, 0, 0, 4'b0000, 1};

    @(negedge clk);

    // Reset held two cycles with a valid code 3 present.
    step(1, 1, 3);
    step(1, 1, 3);
    step(0, 0, 0);
    chk("rst.ready", int'(ia.ready), 1);
    chk("rst.busy",  int'(ia.busy), 0);
    chk("rst.D",     int'(dut_d(0)), 0);

    for (int k = 0; k < 11; k++) begin
      step(tbl[k].r, tbl[k].v, tbl[k].idx);
      chk($sformatf("tbl%0d.D", k),     int'(dut_d(0)), int'(tbl[k].d));
      chk($sformatf("tbl%0d.ready", k), int'(ia.ready), int'(tbl[k].rdy));
    end

    // Sweep codes 0..3 with valid held high; next code presented after each accept.
    begin
      int sw = 0;
      for (int c = 0; c < 30; c++) begin
        step(0, 1, sw % 4);
        if (acc_v[0] && acc[0] == edges) sw++;
      end
    end

    // Five acceptances of code 0 on DUT A; counters saturate at 3.
    step(1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0);
      for (int w = 0; w < 20 && !m_ready(0); w++) step(0, 0, 0);
    end
`ifdef DEC_COUNTERS_EN
    chk("sat.cnt0", int'(ia.cnt0), 3);
    chk("sat.cnt1", int'(ia.cnt1), 0);
    chk("sat.cnt2", int'(ia.cnt2), 0);
    chk("sat.cnt3", int'(ia.cnt3), 0);
`endif

    // DUT B (HOLD=1, GAP=0): one-cycle pulses with an IDLE cycle between.
    step(1, 0, 0);
    step(0, 1, 1);
    chk("B1.D", int'(dut_d(1)), 4'b0010);
    chk("B1.ready", int'(ib.ready), 0);
    step(0, 1, 1);
    chk("B2.D", int'(dut_d(1)), 4'b0000);
    chk("B2.ready", int'(ib.ready), 1);
    step(0, 1, 1);
    chk("B3.D", int'(dut_d(1)), 4'b0010);

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/priority_line_decoder.md
# priority_line_decoder

- Registered 2-to-4 line decoder: the receive-side counterpart of the 4-to-2 priority encoder.
- Accepts an encoded index {A1,A0} with a valid/ready handshake and drives exactly one of D3..D0 high for a programmable number of cycles.
- Inserts a programmable all-low gap after each pulse, then accepts the next code.
- Sits downstream of the encoder; turns its encoded output back into timed one-hot request lines.

## Interface
Parameters:
- HOLD_CYCLES, 4, cycles the selected D line stays high; legal range 1..255.
- GAP_CYCLES, 1, all-low cycles after each pulse; 0 allowed (gap skipped); legal range 0..255.
- CNT_W, 8, width of the per-line event counters (used only with DEC_COUNTERS_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- A1  in  1  encoded index MSB.
- A0  in  1  encoded index LSB.
- valid  in  1  code on A1/A0 is valid.
- ready  out  1  block can accept a code this cycle.
- D3..D0  out  1 each  one-hot decoded lines; index {A1,A0}=3 drives D3 … 0 drives D0.
- busy  out  1  high while pulsing or in gap.
- cnt3..cnt0  out  CNT_W each  accepted-code counters per line; present only with DEC_COUNTERS_EN.

## Operation
- FSM states: IDLE, DRIVE, GAP.
- IDLE:
  - ready=1, busy=0, all D low.
  - On valid&&ready: latch {A1,A0}, load hold counter with HOLD_CYCLES-1, go to DRIVE.
- DRIVE:
  - D[latched index]=1, others 0; ready=0, busy=1.
  - Counter decrements each cycle.
  - At counter 0: if GAP_CYCLES>0, load GAP_CYCLES-1 and go to GAP; else go to IDLE.
- GAP:
  - All D low; ready=0, busy=1.
  - At counter 0, go to IDLE.
- While ready=0, valid is ignored; A1/A0 changes have no effect (index is latched).
- D outputs come directly from registers; no combinational path from A1/A0/valid to D.
- Exactly one D line is high in DRIVE; never more than one in any cycle.
- Reset values: ready=1, busy=0, D3..D0=0, state=IDLE, counters=0.
- Reset mid-operation: outputs return to reset values at the next edge and any pulse is truncated.
- rst takes priority over valid in the same cycle; that code is not accepted.

## Timing
- Code accepted at edge N → selected D high from cycle N+1 through N+HOLD_CYCLES.
- Gap occupies cycles N+HOLD_CYCLES+1 … N+HOLD_CYCLES+GAP_CYCLES.
- ready rises in cycle N+HOLD_CYCLES+GAP_CYCLES+1.
- Maximum throughput: one code per HOLD_CYCLES+GAP_CYCLES+1 cycles.
- GAP_CYCLES=0, HOLD_CYCLES=1: D pulses one cycle, ready back the following cycle (one code per 2 cycles).
- Back-to-back codes with the same index always produce separated pulses. With GAP_CYCLES=0 the separation comes from the IDLE cycle.

## Configuration
- DEC_COUNTERS_EN defined:
  - cnt3..cnt0 ports and registers exist.
  - cnt[i] increments at the acceptance edge when the latched index is i.
  - Counters saturate at 2^CNT_W−1 (no wrap).
  - Cleared only by rst.
- DEC_COUNTERS_EN undefined:
  - Counter registers and ports are absent.
  - Decoding and handshake behaviour is otherwise identical.

## Structure
- Shared package priority_pkg holds:
  - State encoding constants ST_IDLE=2'd0, ST_DRIVE=2'd1, ST_GAP=2'd2.
  - Index width constant IDX_W=2.
- One sub-module, hold_counter:
  - Loadable down-counter, 8-bit, with load/value/zero flag.
  - Used for both the HOLD and GAP phases.
- Decode and FSM live in the top module.

## Test plan
- Reset: assert rst 2 cycles with valid=1, {A1,A0}=2'b11 → after release ready=1, busy=0, D3..D0=0000, cnt*=0.
- Single code, defaults: {A1,A0}=2'b10, valid for 1 cycle at edge N → D2=1 exactly in cycles N+1..N+4, then 1 low gap cycle, ready=1 at N+6.
- Sweep all four codes back-to-back, valid held high → D0..D3 pulse in order, one-hot each time, never overlapping.
- Input change while busy: accept 2'b01, then change A1/A0 to 2'b11 during DRIVE → only D1 pulses.
- Reset mid-DRIVE: assert rst in the second DRIVE cycle → D low and ready=1 at the next edge.
- With DEC_COUNTERS_EN and CNT_W=2: accept code 0 five times → cnt0=3 (saturated), cnt1..cnt3=0.
- With HOLD_CYCLES=1, GAP_CYCLES=0: accept two codes with valid held high → D pulses one cycle each, with a 1-cycle IDLE between.
